ifft8_seq: RTL and testbench

Sequential 8-point radix-2 decimation-in-time inverse FFT on packed Q8.8 complex samples. It is the return path for the team's combinational 8-point forward FFT: it takes a natural-order spectrum X[0..7] one sample per beat and returns time samples x[0..7] one per beat. It reuses a single butterfly unit over 12 cycles. Valid/ready handshakes on both sides let it sit between stream buffers.

---
 rtl/fft_pkg.sv | 34 +++
 rtl/ifft_bfly.sv | 47 ++++
 rtl/ifft8_seq.sv | 116 +++++++++++
 tb/tb_ifft8_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the 8-point inverse FFT: complex Q8.8 sample,
// conjugate twiddles, bit-reversal helper and the sequencer state encoding.
package fft_pkg;

   typedef struct packed {
      logic signed [15:0] re;
      logic signed [15:0] im;
   } cplx_t;

   localparam logic [31:0] W_NEG0 = 32'h0100_0000;
   localparam logic [31:0] W_NEG1 = 32'h00b5_00b5;
   localparam logic [31:0] W_NEG2 = 32'h0000_0100;
   localparam logic [31:0] W_NEG3 = 32'hff4b_00b5;

   typedef enum logic [1:0] {
      ST_LOAD    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_UNLOAD  = 2'd2
   } state_t;

   function automatic logic [2:0] bitrev3(input logic [2:0] k);
      return {k[0], k[1], k[2]};
   endfunction

   function automatic logic [31:0] twiddle(input logic [1:0] t);
      case (t)
         2'd0:    return W_NEG0;
         2'd1:    return W_NEG1;
         2'd2:    return W_NEG2;
         default: return W_NEG3;
      endcase
   endfunction

endpackage

// File: rtl/ifft_bfly.sv
// Combinational radix-2 butterfly: a' = a + w*b, b' = a - w*b in Q8.8 with wrap.
// IFFT8_SCALE_EN: when defined, both outputs are arithmetic-shifted right by one.
import fft_pkg::*;

module ifft_bfly (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] tw,
   output logic [31:0] a_new,
   output logic [31:0] b_new
);

   function automatic logic signed [15:0] trunc_q(input logic signed [31:0] p);
      return p[23:8];
   endfunction

   function automatic logic signed [15:0] scale(input logic signed [15:0] v);
`ifdef IFFT8_SCALE_EN
      return v >>> 1;
`else
      return v;
`endif
   endfunction

   cplx_t av, bv, wv, mv, sv, dv;
   logic signed [31:0] p_ac, p_bd, p_ad, p_bc;

   always_comb begin
      av = a;
      bv = b;
      wv = tw;
      p_ac = bv.re * wv.re;
      p_bd = bv.im * wv.im;
      p_ad = bv.re * wv.im;
      p_bc = bv.im * wv.re;
      // Each product is truncated before the sum, so rounding matches the reference exactly
      mv.re = trunc_q(p_ac) - trunc_q(p_bd);
      mv.im = trunc_q(p_ad) + trunc_q(p_bc);
      sv.re = scale(av.re + mv.re);
      sv.im = scale(av.im + mv.im);
      dv.re = scale(av.re - mv.re);
      dv.im = scale(av.im - mv.im);
      a_new = sv;
      b_new = dv;
   end

endmodule

// File: rtl/ifft8_seq.sv
// Sequential 8-point DIT inverse FFT: loads a spectrum in bit-reversed order,
// runs 12 in-place butterflies, then streams x[0..7]. Scaling via IFFT8_SCALE_EN.
import fft_pkg::*;

module ifft8_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic        busy
);

   state_t      state, state_nx;
   logic [2:0]  in_cnt;
   logic [3:0]  bf_cnt;
   logic [2:0]  out_cnt;
   logic [31:0] mem [8];

   logic        accept, out_take;
   logic [2:0]  addr_a, addr_b;
   logic [1:0]  tw_idx;
   logic [31:0] bf_a_new, bf_b_new;

   assign accept   = in_valid && in_ready;
   assign out_take = out_valid && out_ready;
   assign busy     = (state != ST_LOAD);

   always_comb begin
      state_nx = state;
      case (state)
         ST_LOAD:    if (accept && in_cnt == 3'd7) state_nx = ST_COMPUTE;
         ST_COMPUTE: if (bf_cnt == 4'd11) state_nx = ST_UNLOAD;
         ST_UNLOAD:  if (out_take && out_last) state_nx = ST_LOAD;
         default:    state_nx = ST_LOAD;
      endcase
   end

   // bf_cnt[3:2] selects the stage (span 1, 2, 4); bf_cnt[1:0] walks group then j
   always_comb begin
      addr_a = 3'd0;
      addr_b = 3'd1;
      tw_idx = 2'd0;
      case (bf_cnt[3:2])
         2'd0: begin
            addr_a = {bf_cnt[1:0], 1'b0};
            addr_b = {bf_cnt[1:0], 1'b1};
            tw_idx = 2'd0;
         end
         2'd1: begin
            addr_a = {bf_cnt[1], 1'b0, bf_cnt[0]};
            addr_b = {bf_cnt[1], 1'b1, bf_cnt[0]};
            tw_idx = {bf_cnt[0], 1'b0};
         end
         default: begin
            addr_a = {1'b0, bf_cnt[1:0]};
            addr_b = {1'b1, bf_cnt[1:0]};
            tw_idx = bf_cnt[1:0];
         end
      endcase
   end

   ifft_bfly u_bfly (
      .a     (mem[addr_a]),
      .b     (mem[addr_b]),
      .tw    (twiddle(tw_idx)),
      .a_new (bf_a_new),
      .b_new (bf_b_new)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_LOAD;
         in_cnt    <= 3'd0;
         bf_cnt    <= 4'd0;
         out_cnt   <= 3'd0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= 32'd0;
         out_last  <= 1'b0;
      end else begin
         state    <= state_nx;
         in_ready <= (state_nx == ST_LOAD);
         if (accept)
            in_cnt <= in_cnt + 3'd1;
         if (state == ST_COMPUTE)
            bf_cnt <= (bf_cnt == 4'd11) ? 4'd0 : bf_cnt + 4'd1;
         // Output register refills only when empty or being consumed
         if (state == ST_UNLOAD && (!out_valid || out_ready)) begin
            if (out_valid && out_last) begin
               out_valid <= 1'b0;
               out_last  <= 1'b0;
            end else begin
               out_data  <= mem[out_cnt];
               out_last  <= (out_cnt == 3'd7);
               out_valid <= 1'b1;
               out_cnt   <= out_cnt + 3'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         mem[bitrev3(in_cnt)] <= in_data;
      end else if (state == ST_COMPUTE) begin
         mem[addr_a] <= bf_a_new;
         mem[addr_b] <= bf_b_new;
      end
   end

endmodule

// File: tb/tb_ifft8_seq.sv
// Self-checking bench for ifft8_seq: table of spectra with expected time frames,
// scoreboard on the output stream, plus backpressure and mid-compute reset sequences.
module tb_ifft8_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        busy;

   ifft8_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0][31:0] x;
      logic [7:0][31:0] y;
   } vec_t;

   int          n_vec = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          rx_cnt = 0;
   int          first_cyc = 0;
   logic [32:0] exp_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: every consumed beat is compared against the next expected {last, data}
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_beat: got %h, expected no output", {out_last, out_data});
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            if ({out_last, out_data} !== e) begin
               n_bad++;
               $display("FAIL beat%0d: got %h, expected %h", rx_cnt, {out_last, out_data}, e);
            end
            rx_cnt++;
            if (rx_cnt == 1) first_cyc = cyc;
         end
      end
   end

   function automatic logic signed [15:0] tq(input logic signed [31:0] p);
      return p[23:8];
   endfunction

   function automatic logic [7:0][31:0] ref_ifft(input logic [7:0][31:0] xin);
      logic signed [15:0] re [8];
      logic signed [15:0] im [8];
      logic signed [15:0] wr [4];
      logic signed [15:0] wi [4];
      logic signed [31:0] p0, p1, p2, p3;
      logic signed [15:0] mr, mi, ar, ai, br, bi;
      logic [2:0] kk, rk;
      logic [7:0][31:0] yout;
      wr = '{16'sd256, 16'sd181, 16'sd0, -16'sd181};
      wi = '{16'sd0, 16'sd181, 16'sd256, 16'sd181};
      for (int k = 0; k < 8; k++) begin
         kk = 3'(k);
         rk = {kk[0], kk[1], kk[2]};
         re[rk] = xin[k][31:16];
         im[rk] = xin[k][15:0];
      end
      for (int s = 0; s < 3; s++) begin
         for (int g = 0; g < (4 >> s); g++) begin
            for (int j = 0; j < (1 << s); j++) begin
               int h, p, q, t;
               h = 1 << s;
               p = g * 2 * h + j;
               q = p + h;
               t = j * (4 / h);
               p0 = re[q] * wr[t];
               p1 = im[q] * wi[t];
               p2 = re[q] * wi[t];
               p3 = im[q] * wr[t];
               mr = tq(p0) - tq(p1);
               mi = tq(p2) + tq(p3);
               ar = re[p] + mr;
               ai = im[p] + mi;
               br = re[p] - mr;
               bi = im[p] - mi;
`ifdef IFFT8_SCALE_EN
               ar = ar >>> 1;
               ai = ai >>> 1;
               br = br >>> 1;
               bi = bi >>> 1;
`endif
               re[p] = ar; im[p] = ai;
               re[q] = br; im[q] = bi;
            end
         end
      end
      for (int n = 0; n < 8; n++) yout[n] = {re[n], im[n]};
      return yout;
   endfunction

   task automatic send_frame(input logic [7:0][31:0] xin, input logic [7:0][31:0] yexp,
                             input bit push, input int gap, output int t_acc);
      int budget;
      rx_cnt = 0;
      if (push)
         for (int n = 0; n < 8; n++) exp_q.push_back({(n == 7), yexp[n]});
      for (int k = 0; k < 8; k++) begin
         in_data  = xin[k];
         in_valid = 1'b1;
         budget = 0;
         while (!in_ready && budget < 100) begin
            @(posedge clk); #1;
            budget++;
         end
         if (!in_ready) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
         @(posedge clk); #1;
         in_valid = 1'b0;
         for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
         end
      end
      t_acc = cyc;
   endtask

   task automatic wait_drain(output bit saw_ready);
      int budget;
      budget = 0;
      saw_ready = 1'b0;
      while (exp_q.size() != 0 && budget < 300) begin
         if (in_ready) saw_ready = 1'b1;
         @(posedge clk); #1;
         budget++;
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
   endtask

   vec_t vecs [5];
   logic [7:0][31:0] zero_f, imp_x, imp_y, x1_x;

   initial begin
      int  t_acc;
      bit  saw;
      logic [31:0] held;
      logic [15:0] r0, r1;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 32'd0;
      out_ready = 1'b1;

      zero_f = '0;
      imp_x = zero_f;
      imp_x[0] = 32'h0100_0000;
      x1_x = zero_f;
      x1_x[1] = 32'h0800_0000;

      vecs[0].x = imp_x;
      vecs[1].x = zero_f;
      for (int k = 0; k < 8; k++) vecs[1].x[k] = 32'h0100_0000;
      vecs[2].x = x1_x;
`ifdef IFFT8_SCALE_EN
      for (int n = 0; n < 8; n++) vecs[0].y[n] = 32'h0020_0000;
      vecs[1].y = zero_f;
      vecs[1].y[0] = 32'h0100_0000;
      vecs[2].y = {32'h00b5_ff4b, 32'h0000_ff00, 32'hff4b_ff4b, 32'hff00_0000,
                   32'hff4b_00b5, 32'h0000_0100, 32'h00b5_00b5, 32'h0100_0000};
`else
      for (int n = 0; n < 8; n++) vecs[0].y[n] = 32'h0100_0000;
      vecs[1].y = zero_f;
      vecs[1].y[0] = 32'h0800_0000;
      vecs[2].y = {32'h05a8_fa58, 32'h0000_f800, 32'hfa58_fa58, 32'hf800_0000,
                   32'hfa58_05a8, 32'h0000_0800, 32'h05a8_05a8, 32'h0800_0000};
`endif
      imp_y = vecs[0].y;
      for (int v = 3; v < 5; v++) begin
         for (int k = 0; k < 8; k++) begin
            r0 = 16'($urandom_range(0, 511)) - 16'd256;
            r1 = 16'($urandom_range(0, 511)) - 16'd256;
            vecs[v].x[k] = {r0, r1};
         end
         vecs[v].y = ref_ifft(vecs[v].x);
      end

      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", {63'd0, in_ready}, 64'd0);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_data", {32'd0, out_data}, 64'd0);
      check("rst_out_last", {63'd0, out_last}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("in_ready_after_rst", {63'd0, in_ready}, 64'd1);

      for (int v = 0; v < 5; v++) begin
         send_frame(vecs[v].x, vecs[v].y, 1'b1, (v >= 3) ? v - 2 : 0, t_acc);
         check("busy_after_load", {63'd0, busy}, 64'd1);
         wait_drain(saw);
         check("in_ready_during_frame", {63'd0, saw}, 64'd0);
         if (v == 0) check("latency", 64'(first_cyc - t_acc), 64'd13);
      end

      // Backpressure: hold x[3] for five cycles
      send_frame(x1_x, vecs[2].y, 1'b1, 0, t_acc);
      for (int i = 0; i < 100 && !(out_valid && rx_cnt == 3); i++) begin
         @(posedge clk); #1;
      end
      check("bp_reach_x3", {63'd0, (out_valid && rx_cnt == 3)}, 64'd1);
      out_ready = 1'b0;
      held = out_data;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_hold_data", {32'd0, out_data}, {32'd0, held});
         check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
         check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      end
      out_ready = 1'b1;
      wait_drain(saw);
      check("bp_in_ready_before_x7", {63'd0, saw}, 64'd0);
      check("bp_in_ready_after_x7", {63'd0, in_ready}, 64'd1);
      check("bp_beat_count", 64'(rx_cnt), 64'd8);

      // Reset on the 6th compute cycle discards the frame
      send_frame(imp_x, imp_y, 1'b0, 0, t_acc);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("mid_rst_busy", {63'd0, busy}, 64'd0);
      check("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_in_ready_rise", {63'd0, in_ready}, 64'd1);
      send_frame(imp_x, imp_y, 1'b1, 0, t_acc);
      wait_drain(saw);
      check("post_rst_beats", 64'(rx_cnt), 64'd8);
      repeat (20) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
